// File: rtl/lfsr_test_ctrl.sv
// Frame sequencer for an LFSR test-pattern source. It reseeds the external
// generator before every frame and streams fixed-length frames separated by idle gaps.
module lfsr_test_ctrl #(
    parameter logic [15:0] P_FRAME_LEN = 16'd256,
    parameter logic [7:0]  P_GAP_LEN   = 8'd16,
    parameter logic [15:0] P_FRAME_NUM = 16'd4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_tx_ready,
    output logic        o_lfsr_rst,
    input  logic [31:0] i_lfsr_data,
    output logic [31:0] o_tx_data,
    output logic        o_tx_valid,
    output logic        o_tx_last,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_frame_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_PRIME    = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [7:0]  gcnt_q, gcnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        stop_q, stop_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_last_q, tx_last_d;
    logic        run_complete;

    // A limit of zero means the run continues until a stop request.
    assign run_complete = (P_FRAME_NUM != 16'd0) && (frame_cnt_q == P_FRAME_NUM);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        gcnt_d      = gcnt_q;
        frame_cnt_d = frame_cnt_q;
        stop_d      = stop_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tx_data_d   = 32'd0;
        tx_valid_d  = 1'b0;
        tx_last_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d     = S_WAIT_RDY;
                    frame_cnt_d = 16'd0;
                    stop_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_WAIT_RDY: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (i_tx_ready) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                if (i_stop) begin
                    stop_d = 1'b1;
                end
                state_d = S_SEND;
                wcnt_d  = 16'd0;
            end
            S_SEND: begin
                if (i_stop) begin
                    stop_d = 1'b1;
                end
                tx_data_d  = i_lfsr_data;
                tx_valid_d = 1'b1;
                if (wcnt_q == P_FRAME_LEN - 16'd1) begin
                    tx_last_d   = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    wcnt_d      = 16'd0;
                    gcnt_d      = 8'd0;
                    state_d     = S_GAP;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (i_stop) begin
                    stop_d = 1'b1;
                end
                if (gcnt_q == P_GAP_LEN - 8'd1) begin
                    gcnt_d = 8'd0;
                    // A stop arriving in the last gap cycle still ends the run here.
                    if (stop_q || i_stop || run_complete) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_RDY;
                    end
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 16'd0;
            gcnt_q      <= 8'd0;
            frame_cnt_q <= 16'd0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_data_q   <= 32'd0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            gcnt_q      <= gcnt_d;
            frame_cnt_q <= frame_cnt_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
        end
    end

    // The generator runs only while priming or sending, so each frame restarts at the seed.
    assign o_lfsr_rst  = !((state_q == S_PRIME) || (state_q == S_SEND));
    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_tx_last   = tx_last_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lfsr_test_ctrl.sv
// Bench for lfsr_test_ctrl: a seeded 16-bit Galois LFSR stands in for the generator.
// The default-parameter instance runs long sequences; a 1/1/3 instance is driven from a vector table.
module tb_lfsr_test_ctrl;

    localparam logic [15:0] SEED      = 16'hA076;
    localparam int          FRAME_LEN = 256;
    localparam int          GAP_LEN   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, stop, ready, lrst, txValid, txLast, busy, done;
    logic [31:0] lfsrData, txData;
    logic [15:0] frameCnt;
    logic        startS, stopS, readyS, lrstS, txValidS, txLastS, busyS, doneS;
    logic [31:0] lfsrDataS, txDataS;
    logic [15:0] frameCntS;
    logic [15:0] genState, genStateS;

    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [31:0] lfsrWord(input logic [15:0] s);
        return {s, lfsrNext(s)};
    endfunction

    // Generator model: one cycle of output latency, reseeded while lrst is high.
    always @(posedge clk) begin
        if (lrst) begin
            genState <= SEED;
            lfsrData <= 32'd0;
        end else begin
            genState <= lfsrNext(genState);
            lfsrData <= lfsrWord(genState);
        end
    end

    always @(posedge clk) begin
        if (lrstS) begin
            genStateS <= SEED;
            lfsrDataS <= 32'd0;
        end else begin
            genStateS <= lfsrNext(genStateS);
            lfsrDataS <= lfsrWord(genStateS);
        end
    end

    lfsr_test_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_tx_ready(ready),
        .o_lfsr_rst(lrst), .i_lfsr_data(lfsrData), .o_tx_data(txData), .o_tx_valid(txValid),
        .o_tx_last(txLast), .o_busy(busy), .o_done(done), .o_frame_cnt(frameCnt)
    );

    lfsr_test_ctrl #(.P_FRAME_LEN(16'd1), .P_GAP_LEN(8'd1), .P_FRAME_NUM(16'd3)) dutSmall (
        .i_clk(clk), .i_rst(rst), .i_start(startS), .i_stop(stopS), .i_tx_ready(readyS),
        .o_lfsr_rst(lrstS), .i_lfsr_data(lfsrDataS), .o_tx_data(txDataS), .o_tx_valid(txValidS),
        .o_tx_last(txLastS), .o_busy(busyS), .o_done(doneS), .o_frame_cnt(frameCntS)
    );

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    logic [31:0] expWord [FRAME_LEN];
    bit monEn = 1'b0;
    int wordIdx, framesSeen, idleRun, doneCnt;

    // Stream monitor for the default instance, sampling 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (monEn) begin
            if (txValid) begin
                // Idle output cycles between frames: 15 remaining gap + wait + prime + first send.
                if (wordIdx == 0 && framesSeen > 0)
                    checkOutput("gapLen", 64'(idleRun), 64'(GAP_LEN + 2));
                checkOutput("word", 64'(txData), 64'(expWord[wordIdx]));
                checkOutput("last", 64'(txLast), 64'(wordIdx == FRAME_LEN - 1));
                idleRun = 0;
                if (wordIdx == FRAME_LEN - 1) begin
                    checkOutput("frameCntIncr", 64'(frameCnt), 64'(framesSeen + 1));
                    framesSeen++;
                    wordIdx = 0;
                end else begin
                    wordIdx++;
                end
            end else begin
                idleRun++;
            end
            if (done) begin
                checkOutput("doneGap", 64'(idleRun), 64'(GAP_LEN));
                doneCnt++;
            end
        end
    end

    task automatic clearMonitor();
        wordIdx = 0; framesSeen = 0; idleRun = 0; doneCnt = 0;
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic r);
        start = s; stop = p; ready = r;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) checkOutput({name, "Timeout"}, 64'd0, 64'd1);
    endtask

    task automatic waitWord(input string name, input int f, input int w, input int budget);
        int n = 0;
        while (!(framesSeen == f && wordIdx == w) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(framesSeen == f && wordIdx == w)) checkOutput({name, "Timeout"}, 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [2:0]  stim;   // {start, stop, ready}
        logic [4:0]  flags;  // {valid, last, busy, done, lfsr_rst}
        logic [15:0] cnt;
        logic [31:0] data;
    } vecT;

    vecT vecs [18];

    initial begin
        logic [15:0] s;
        logic [31:0] w0;
        int bad;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        startS = 1'b0; stopS = 1'b0; readyS = 1'b0;
        s = SEED;
        for (int k = 0; k < FRAME_LEN; k++) begin
            expWord[k] = lfsrWord(s);
            s = lfsrNext(s);
        end
        w0 = expWord[0];

        vecs[0]  = '{3'b100, 5'b00101, 16'd0, 32'd0};
        vecs[1]  = '{3'b001, 5'b00100, 16'd0, 32'd0};
        vecs[2]  = '{3'b001, 5'b00100, 16'd0, 32'd0};
        vecs[3]  = '{3'b001, 5'b11101, 16'd1, w0};
        vecs[4]  = '{3'b001, 5'b00101, 16'd1, 32'd0};
        vecs[5]  = '{3'b001, 5'b00100, 16'd1, 32'd0};
        vecs[6]  = '{3'b001, 5'b00100, 16'd1, 32'd0};
        vecs[7]  = '{3'b001, 5'b11101, 16'd2, w0};
        vecs[8]  = '{3'b001, 5'b00101, 16'd2, 32'd0};
        vecs[9]  = '{3'b001, 5'b00100, 16'd2, 32'd0};
        vecs[10] = '{3'b001, 5'b00100, 16'd2, 32'd0};
        vecs[11] = '{3'b001, 5'b11101, 16'd3, w0};
        vecs[12] = '{3'b001, 5'b00011, 16'd3, 32'd0};
        vecs[13] = '{3'b001, 5'b00001, 16'd3, 32'd0};
        vecs[14] = '{3'b110, 5'b00101, 16'd0, 32'd0};
        vecs[15] = '{3'b000, 5'b00101, 16'd0, 32'd0};
        vecs[16] = '{3'b010, 5'b00011, 16'd0, 32'd0};
        vecs[17] = '{3'b000, 5'b00001, 16'd0, 32'd0};

        @(negedge clk);
        @(negedge clk);
        checkOutput("resetDefault", {11'd0, txValid, txLast, busy, done, lrst, frameCnt, txData},
                    {11'd0, 5'b00001, 16'd0, 32'd0});
        checkOutput("resetSmall", {11'd0, txValidS, txLastS, busyS, doneS, lrstS, frameCntS, txDataS},
                    {11'd0, 5'b00001, 16'd0, 32'd0});
        rst = 1'b0;
        @(negedge clk);

        // Single-word frames, then start+stop together and a stop while waiting for ready.
        for (int i = 0; i < 18; i++) begin
            {startS, stopS, readyS} = vecs[i].stim;
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i),
                        {11'd0, txValidS, txLastS, busyS, doneS, lrstS, frameCntS, txDataS},
                        {11'd0, vecs[i].flags, vecs[i].cnt, vecs[i].data});
        end

        // Full default run with a stray start pulse mid-run.
        clearMonitor();
        monEn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("busyAfterStart", 64'(busy), 64'd1);
        repeat (300) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitDone("runA", 6000);
        checkOutput("runAFrames", 64'(framesSeen), 64'd4);
        checkOutput("runAState", {busy, done, frameCnt}, {1'b0, 1'b1, 16'd4});
        @(negedge clk);
        checkOutput("runADonePulse", {busy, done, frameCnt}, {1'b0, 1'b0, 16'd4});
        checkOutput("runADoneCount", 64'(doneCnt), 64'd1);

        // Ready held low at the first frame, then a stop during frame 2.
        clearMonitor();
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (txValid !== 1'b0 || lrst !== 1'b1 || busy !== 1'b1) bad++;
        end
        checkOutput("readyLowHold", 64'(bad), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("primeCycle", {lrst, txValid}, 2'b00);
        @(negedge clk);
        checkOutput("sendFirstCycle", {lrst, txValid}, 2'b00);
        @(negedge clk);
        checkOutput("firstValid", {txValid, txData}, {1'b1, expWord[0]});
        waitWord("stopPoint", 1, 100, 1000);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitDone("runB", 2000);
        checkOutput("runBFrames", 64'(framesSeen), 64'd2);
        checkOutput("runBState", {busy, done, frameCnt}, {1'b0, 1'b1, 16'd2});

        // Reset in the middle of frame 1, then a fresh run from the seed.
        @(negedge clk);
        clearMonitor();
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitWord("resetPoint", 0, 10, 500);
        checkOutput("preResetValid", 64'(txValid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", {11'd0, txValid, txLast, busy, done, lrst, frameCnt, txData},
                    {11'd0, 5'b00001, 16'd0, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        clearMonitor();
        @(negedge clk);
        checkOutput("postResetIdle", {txValid, busy, lrst}, 3'b001);
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitDone("runC", 6000);
        checkOutput("runCFrames", 64'(framesSeen), 64'd4);
        checkOutput("runCState", {busy, frameCnt}, {1'b0, 16'd4});

        monEn = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/lfsr_test_ctrl.md
LFSR_TEST_CTRL -- requirements
Module: lfsr_test_ctrl

Interface
REQ-001 SHALL have parameter P_FRAME_LEN, default 16'd256, meaning 32-bit words per frame (legal 1..65535).
REQ-002 SHALL have parameter P_GAP_LEN, default 8'd16, meaning idle cycles between frames (legal 1..255).
REQ-003 SHALL have parameter P_FRAME_NUM, default 16'd4, meaning frames per run (0 = unlimited until stop).
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  run request, sampled in IDLE only.
REQ-007 i_stop  input  1  graceful stop request, sampled while busy.
REQ-008 i_tx_ready  input  1  sink ready; checked only at frame start.
REQ-009 o_lfsr_rst  output  1  reset to the 16-bit-state LFSR generator instance (reseeds it).
REQ-010 i_lfsr_data  input  32  generator output word; new word every clock while o_lfsr_rst=0.
REQ-011 o_tx_data  output  32  frame payload word.
REQ-012 o_tx_valid  output  1  o_tx_data valid this cycle.
REQ-013 o_tx_last  output  1  final word of frame, qualified by o_tx_valid.
REQ-014 o_busy  output  1  run in progress.
REQ-015 o_done  output  1  one-cycle pulse at run end.
REQ-016 o_frame_cnt  output  16  frames completed in current/last run.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_RDY, PRIME, SEND, GAP.
REQ-018 IDLE: i_start=1 -> WAIT_RDY, clear o_frame_cnt, o_busy=1 from next cycle.
REQ-019 WAIT_RDY: i_tx_ready=1 -> PRIME; else remain; i_stop=1 here -> IDLE with o_done pulse.
REQ-020 o_lfsr_rst SHALL be 1 in IDLE, WAIT_RDY, GAP and 0 in PRIME and SEND, so every frame starts from the generator seed.
REQ-021 PRIME SHALL last exactly 1 cycle (generator output latency), then SEND.
REQ-022 SEND SHALL last exactly P_FRAME_LEN cycles, counted by a 16-bit word counter.
REQ-023 Word on i_lfsr_data in SEND cycle k SHALL appear registered on o_tx_data at cycle k+1 with o_tx_valid=1; latency 1 cycle.
REQ-024 o_tx_last SHALL be 1 only with word P_FRAME_LEN-1; P_FRAME_LEN=1 gives valid and last together.
REQ-025 o_tx_valid SHALL be contiguous within a frame; i_tx_ready is ignored mid-frame (no backpressure).
REQ-026 o_frame_cnt SHALL increment in the cycle o_tx_last is output; wraps 16'hFFFF -> 0 when P_FRAME_NUM=0.
REQ-027 After SEND -> GAP for P_GAP_LEN cycles; o_tx_valid=0, o_tx_data holds 0.
REQ-028 GAP end: if stop latched or frame count reached P_FRAME_NUM (nonzero) -> IDLE, o_done=1 one cycle, o_busy=0; else -> WAIT_RDY.
REQ-029 i_stop during SEND/GAP SHALL be latched; current frame never truncated.
REQ-030 i_start while busy SHALL be ignored; i_start and i_stop same cycle in IDLE: start wins, stop ignored.

Reset
REQ-031 On i_rst=1 (any time, incl. mid-frame): state IDLE, o_lfsr_rst=1, o_tx_data=0, o_tx_valid=0, o_tx_last=0, o_busy=0, o_done=0, o_frame_cnt=0, counters and stop latch cleared; no partial frame resumes.

Verification
REQ-032 Defaults, i_tx_ready=1, i_start pulse -> 4 frames of 256 valid words, last on each 256th, 16 idle cycles between, o_done after 4th gap, o_frame_cnt=4.
REQ-033 Each frame's words SHALL match a reference LFSR model from seed 16'hA076 word-for-word, identical across frames.
REQ-034 i_tx_ready=0 for 50 cycles at WAIT_RDY -> no o_tx_valid, o_lfsr_rst=1 held; frame starts 2 cycles after ready rises.
REQ-035 i_stop at word 100 of frame 2 -> frame 2 completes 256 words, gap, o_done, o_frame_cnt=2.
REQ-036 i_rst asserted at word 10 of frame 1 -> all outputs reset same cycle; new i_start gives fresh frame from seed.
REQ-037 P_FRAME_LEN=1, P_GAP_LEN=1, P_FRAME_NUM=3 -> three single-word frames with valid and last together, o_done, o_frame_cnt=3.
